// File: rtl/sfm_fma_arbiter.sv
// Round-robin arbiter with lockable ownership that shares one fixed-latency FMA among N_REQ requesters.
// Optional per-requester issue/stall counters are enabled with SFM_ARB_PERF_CNT_EN.
module sfm_fma_arbiter #(
    parameter int N_REQ    = 2,
    parameter int FMA_REGS = 3,
    parameter int WIDTH    = 16,
    parameter int CNT_W    = 32,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ-1:0]         req_lock_i,
    input  logic [N_REQ*WIDTH-1:0]   req_a_i,
    input  logic [N_REQ*WIDTH-1:0]   req_b_i,
    input  logic [N_REQ*WIDTH-1:0]   req_c_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     fma_valid_o,
    output logic [WIDTH-1:0]         fma_a_o,
    output logic [WIDTH-1:0]         fma_b_o,
    output logic [WIDTH-1:0]         fma_c_o,
    input  logic [WIDTH-1:0]         fma_res_i,
    output logic [N_REQ-1:0]         res_valid_o,
    output logic [WIDTH-1:0]         res_o,
    output logic [IDX_W-1:0]         owner_o,
    output logic                     locked_o,
`ifdef SFM_ARB_PERF_CNT_EN
    output logic [N_REQ*CNT_W-1:0]   issue_cnt_o,
    output logic [N_REQ*CNT_W-1:0]   stall_cnt_o,
`endif
    output logic                     busy_o
);

    typedef enum logic [0:0] {
        S_ARB    = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;

    logic             w_arb_found;
    logic [IDX_W-1:0] w_arb_idx;
    logic [IDX_W-1:0] w_grant;
    logic             w_issue;
    logic [N_REQ-1:0] w_ready;

    logic             w_head_valid;
    logic [IDX_W-1:0] w_head_idx;

    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_REQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_arb_found && req_valid_i[(int'(r_ptr) + k) % N_REQ]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = IDX_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    // Grant selection and next-state; clear_i suppresses any grant in its cycle.
    always_comb begin
        w_ready     = '0;
        w_grant     = w_arb_idx;
        w_issue     = 1'b0;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        case (r_state)
            S_LOCKED: begin
                w_grant          = r_owner;
                w_ready[r_owner] = ~clear_i;
                w_issue          = req_valid_i[r_owner] & ~clear_i;
                if (!req_lock_i[r_owner]) begin
                    w_state_nxt = S_ARB;
                    if (w_issue) begin
                        w_ptr_nxt = nextIdx(r_owner);
                    end
                end
            end
            default: begin
                w_grant            = w_arb_idx;
                w_ready[w_arb_idx] = w_arb_found & ~clear_i;
                w_issue            = w_arb_found & ~clear_i;
                if (w_issue) begin
                    w_ptr_nxt = nextIdx(w_arb_idx);
                    if (req_lock_i[w_arb_idx]) begin
                        w_owner_nxt = w_arb_idx;
                        w_state_nxt = S_LOCKED;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_ARB;
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (clear_i) begin
            r_state <= S_ARB;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign req_ready_o = w_ready;
    assign fma_valid_o = w_issue;
    assign fma_a_o     = w_issue ? req_a_i[int'(w_grant)*WIDTH +: WIDTH] : '0;
    assign fma_b_o     = w_issue ? req_b_i[int'(w_grant)*WIDTH +: WIDTH] : '0;
    assign fma_c_o     = w_issue ? req_c_i[int'(w_grant)*WIDTH +: WIDTH] : '0;
    assign owner_o     = r_owner;
    assign locked_o    = (r_state == S_LOCKED);

    // Tag pipeline mirrors the FMA depth so each result finds its issuer.
    generate
        if (FMA_REGS == 0) begin : g_comb_fma
            assign w_head_valid = w_issue;
            assign w_head_idx   = w_grant;
            assign busy_o       = 1'b0;
        end else begin : g_tag_pipe
            logic [FMA_REGS-1:0] r_tag_valid;
            logic [IDX_W-1:0]    r_tag_idx [FMA_REGS];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_tag_valid <= '0;
                    for (int s = 0; s < FMA_REGS; s++) begin
                        r_tag_idx[s] <= '0;
                    end
                end else if (clear_i) begin
                    r_tag_valid <= '0;
                    for (int s = 0; s < FMA_REGS; s++) begin
                        r_tag_idx[s] <= '0;
                    end
                end else begin
                    r_tag_valid[0] <= w_issue;
                    r_tag_idx[0]   <= w_grant;
                    for (int s = 1; s < FMA_REGS; s++) begin
                        r_tag_valid[s] <= r_tag_valid[s-1];
                        r_tag_idx[s]   <= r_tag_idx[s-1];
                    end
                end
            end

            assign w_head_valid = r_tag_valid[FMA_REGS-1];
            assign w_head_idx   = r_tag_idx[FMA_REGS-1];
            assign busy_o       = |r_tag_valid;
        end
    endgenerate

    always_comb begin
        res_valid_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            res_valid_o[i] = w_head_valid & ~clear_i & (w_head_idx == IDX_W'(i));
        end
    end

    assign res_o = (w_head_valid & ~clear_i) ? fma_res_i : '0;

`ifdef SFM_ARB_PERF_CNT_EN
    // Saturating counters; they stick at all-ones rather than wrapping.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
            logic [CNT_W-1:0] r_issue_cnt;
            logic [CNT_W-1:0] r_stall_cnt;
            logic             w_issue_hit;
            logic             w_stall_hit;

            assign w_issue_hit = w_issue & (w_grant == IDX_W'(gi));
            assign w_stall_hit = req_valid_i[gi] & ~w_ready[gi];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_issue_cnt <= '0;
                    r_stall_cnt <= '0;
                end else if (clear_i) begin
                    r_issue_cnt <= '0;
                    r_stall_cnt <= '0;
                end else begin
                    if (w_issue_hit && (r_issue_cnt != '1)) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                    if (w_stall_hit && (r_stall_cnt != '1)) begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                end
            end

            assign issue_cnt_o[gi*CNT_W +: CNT_W] = r_issue_cnt;
            assign stall_cnt_o[gi*CNT_W +: CNT_W] = r_stall_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_sfm_fma_arbiter.sv
// Directed self-checking bench for sfm_fma_arbiter (N_REQ=2, FMA_REGS=3, WIDTH=16).
// With SFM_ARB_PERF_CNT_EN defined the DUT is built with 4-bit counters to reach saturation quickly.
module tb_sfm_fma_arbiter;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic [1:0]    req_valid_i;
    logic [1:0]    req_lock_i;
    logic [2*W-1:0] req_a_i, req_b_i, req_c_i;
    logic [1:0]    req_ready_o;
    logic          fma_valid_o;
    logic [W-1:0]  fma_a_o, fma_b_o, fma_c_o;
    logic [W-1:0]  fma_res_i;
    logic [1:0]    res_valid_o;
    logic [W-1:0]  res_o;
    logic [0:0]    owner_o;
    logic          locked_o;
    logic          busy_o;
`ifdef SFM_ARB_PERF_CNT_EN
    logic [2*CW-1:0] issue_cnt_o, stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    sfm_fma_arbiter #(
        .N_REQ(2), .FMA_REGS(3), .WIDTH(W), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_lock_i(req_lock_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
        .req_ready_o(req_ready_o), .fma_valid_o(fma_valid_o),
        .fma_a_o(fma_a_o), .fma_b_o(fma_b_o), .fma_c_o(fma_c_o),
        .fma_res_i(fma_res_i), .res_valid_o(res_valid_o), .res_o(res_o),
        .owner_o(owner_o), .locked_o(locked_o),
`ifdef SFM_ARB_PERF_CNT_EN
        .issue_cnt_o(issue_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic nextCycle();
        @(negedge clk_i);
    endtask

    task automatic idleInputs();
        clear_i     = 1'b0;
        req_valid_i = 2'b00;
        req_lock_i  = 2'b00;
        req_a_i     = {16'h2200, 16'h1100};
        req_b_i     = {16'h2201, 16'h1101};
        req_c_i     = {16'h2202, 16'h1102};
        fma_res_i   = 16'h0000;
    endtask

    task automatic doReset();
        nextCycle();
        idleInputs();
        rst_ni = 1'b0;
        nextCycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        idleInputs();
        rst_ni      = 1'b0;
        req_valid_i = 2'b11;
        clear_i     = 1'b0;
        #12;
        req_valid_i = 2'b00;
        #1;
        checks++; if (req_ready_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready got %b want 00", req_ready_o); end
        checks++; if (fma_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fma_valid got %b want 0", fma_valid_o); end
        checks++; if (res_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_res_valid got %b want 00", res_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (locked_o !== 1'b0 || owner_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_lock got locked=%b owner=%b want 0/0", locked_o, owner_o); end
        checks++; if (fma_a_o !== 16'h0 || res_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_data got a=%h res=%h want 0/0", fma_a_o, res_o); end
        nextCycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        doReset();
        nextCycle();
        req_valid_i = 2'b01;
        req_a_i[15:0] = 16'h3F80;
        req_b_i[15:0] = 16'h4000;
        req_c_i[15:0] = 16'h3F00;
        #1;
        checks++; if (req_ready_o !== 2'b01 || fma_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_issue got ready=%b valid=%b want 01/1", req_ready_o, fma_valid_o); end
        checks++; if ({fma_a_o, fma_b_o, fma_c_o} !== {16'h3F80, 16'h4000, 16'h3F00}) begin errors++; $display("[TB] FAIL single_operands got %h %h %h want 3f80 4000 3f00", fma_a_o, fma_b_o, fma_c_o); end
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            req_valid_i = 2'b00;
            fma_res_i   = (k == 3) ? 16'h4020 : 16'h0BAD;
            #1;
            checks++; if (busy_o !== (k <= 3)) begin errors++; $display("[TB] FAIL single_busy t+%0d got %b want %b", k, busy_o, (k <= 3)); end
            checks++; if (res_valid_o !== ((k == 3) ? 2'b01 : 2'b00)) begin errors++; $display("[TB] FAIL single_res_valid t+%0d got %b want %b", k, res_valid_o, (k == 3) ? 2'b01 : 2'b00); end
            if (k == 3) begin
                checks++; if (res_o !== 16'h4020) begin errors++; $display("[TB] FAIL single_res_data got %h want 4020", res_o); end
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] expGrant [6];
        expGrant = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        doReset();
        for (int k = 0; k < 9; k++) begin
            nextCycle();
            req_valid_i = (k < 6) ? 2'b11 : 2'b00;
            fma_res_i   = 16'h5000 + 16'(k);
            #1;
            if (k < 6) begin
                checks++; if (req_ready_o !== expGrant[k]) begin errors++; $display("[TB] FAIL contention_grant c%0d got %b want %b", k, req_ready_o, expGrant[k]); end
                checks++; if (fma_a_o !== (expGrant[k][0] ? 16'h1100 : 16'h2200)) begin errors++; $display("[TB] FAIL contention_mux c%0d got %h", k, fma_a_o); end
            end
            if (k >= 3) begin
                checks++; if (res_valid_o !== expGrant[k-3]) begin errors++; $display("[TB] FAIL contention_res c%0d got %b want %b", k, res_valid_o, expGrant[k-3]); end
            end else begin
                checks++; if (res_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL contention_res c%0d got %b want 00", k, res_valid_o); end
            end
        end
    endtask

    task automatic test_lock();
        logic [1:0] expReady [6];
        logic       expLocked [6];
        expReady  = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        expLocked = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        doReset();
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            req_valid_i = 2'b11;
            req_lock_i  = (k < 4) ? 2'b10 : 2'b00;
            #1;
            checks++; if (req_ready_o !== expReady[k] || fma_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL lock_grant c%0d got ready=%b valid=%b want %b/1", k, req_ready_o, fma_valid_o, expReady[k]); end
            checks++; if (locked_o !== expLocked[k]) begin errors++; $display("[TB] FAIL lock_state c%0d got %b want %b", k, locked_o, expLocked[k]); end
            if (expLocked[k]) begin
                checks++; if (owner_o !== 1'b1) begin errors++; $display("[TB] FAIL lock_owner c%0d got %b want 1", k, owner_o); end
            end
        end
    endtask

    task automatic test_lock_gap();
        doReset();
        nextCycle();
        req_valid_i = 2'b10;
        req_lock_i  = 2'b10;
        #1;
        checks++; if (fma_valid_o !== 1'b1 || req_ready_o !== 2'b10) begin errors++; $display("[TB] FAIL gap_first got valid=%b ready=%b want 1/10", fma_valid_o, req_ready_o); end
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            req_valid_i = 2'b01;
            req_lock_i  = (k < 3) ? 2'b10 : 2'b00;
            #1;
            checks++; if (req_ready_o !== 2'b10 || fma_valid_o !== 1'b0 || locked_o !== 1'b1) begin errors++; $display("[TB] FAIL gap_hold c%0d got ready=%b valid=%b locked=%b want 10/0/1", k, req_ready_o, fma_valid_o, locked_o); end
        end
        nextCycle();
        req_valid_i = 2'b01;
        req_lock_i  = 2'b00;
        #1;
        checks++; if (req_ready_o !== 2'b01 || fma_valid_o !== 1'b1 || locked_o !== 1'b0) begin errors++; $display("[TB] FAIL gap_release got ready=%b valid=%b locked=%b want 01/1/0", req_ready_o, fma_valid_o, locked_o); end
    endtask

    task automatic test_flush();
        doReset();
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            req_valid_i = 2'b01;
        end
        nextCycle();
        clear_i     = 1'b1;
        req_valid_i = 2'b01;
        #1;
        checks++; if (fma_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin errors++; $display("[TB] FAIL flush_issue got valid=%b ready=%b want 0/00", fma_valid_o, req_ready_o); end
        checks++; if (res_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL flush_res_clear got %b want 00", res_valid_o); end
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            clear_i     = 1'b0;
            req_valid_i = 2'b00;
            #1;
            checks++; if (res_valid_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_after c%0d got res=%b busy=%b want 00/0", k, res_valid_o, busy_o); end
        end
        nextCycle();
        req_valid_i = 2'b11;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("[TB] FAIL flush_pointer got %b want 01", req_ready_o); end
    endtask

`ifdef SFM_ARB_PERF_CNT_EN
    task automatic test_perf();
        doReset();
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            req_valid_i = 2'b11;
        end
        nextCycle();
        req_valid_i = 2'b00;
        #1;
        checks++; if (issue_cnt_o !== {4'd3, 4'd3}) begin errors++; $display("[TB] FAIL perf_issue got %h want 33", issue_cnt_o); end
        checks++; if (stall_cnt_o !== {4'd3, 4'd3}) begin errors++; $display("[TB] FAIL perf_stall got %h want 33", stall_cnt_o); end
        for (int k = 0; k < 40; k++) begin
            nextCycle();
            req_valid_i = 2'b11;
        end
        nextCycle();
        req_valid_i = 2'b00;
        #1;
        checks++; if (issue_cnt_o !== 8'hFF) begin errors++; $display("[TB] FAIL perf_issue_sat got %h want ff", issue_cnt_o); end
        checks++; if (stall_cnt_o !== 8'hFF) begin errors++; $display("[TB] FAIL perf_stall_sat got %h want ff", stall_cnt_o); end
        nextCycle();
        clear_i = 1'b1;
        nextCycle();
        clear_i = 1'b0;
        #1;
        checks++; if (issue_cnt_o !== 8'h00 || stall_cnt_o !== 8'h00) begin errors++; $display("[TB] FAIL perf_clear got %h/%h want 00/00", issue_cnt_o, stall_cnt_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_lock_gap();
        test_flush();
`ifdef SFM_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
